// File: rtl/mb_drive_arb_if.sv
// Massbus drive-arbitration bundle.
// Groups the per-unit request/last/grant vectors, the RH11 handshake
// (devACKI in, devREQO out) and the tenure status outputs.
//   master : drive/RH11 side   -- drives req, last, devACKI
//   slave  : arbiter side      -- drives devREQO, gnt, sel, busy, tmo, wcnt
interface mb_drive_arb_if #(
  parameter int unsigned NUNITS = 8
);
  localparam int unsigned SW = $clog2(NUNITS);

  logic [NUNITS-1:0] req;
  logic [NUNITS-1:0] last;
  logic              devACKI;
  logic              devREQO;
  logic [NUNITS-1:0] gnt;
  logic [SW-1:0]     sel;
  logic              busy;
  logic              tmo;
  logic [15:0]       wcnt;

  modport master (
    output req, last, devACKI,
    input  devREQO, gnt, sel, busy, tmo, wcnt
  );

  modport slave (
    input  req, last, devACKI,
    output devREQO, gnt, sel, busy, tmo, wcnt
  );
endinterface

// File: rtl/mb_drive_arb.sv
// Round-robin arbiter for the drive units sharing the Massbus data path.
// A requesting unit wins a tenure (XFER), its words are counted on devACKI,
// and the tenure ends on last[sel], on the drive dropping req, or on a
// devACKI timeout. A RELEASE cycle advances the round-robin pointer.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   devRESET - Massbus device reset, synchronous active-high (same as rst)
//   bus      - mb_drive_arb_if.slave: req, last, devACKI in;
//              devREQO, gnt, sel, busy, tmo, wcnt out
module mb_drive_arb #(
  parameter int unsigned NUNITS = 8,
  parameter int unsigned TMOCNT = 1023
) (
  input logic           clk,
  input logic           rst,
  input logic           devRESET,
  mb_drive_arb_if.slave bus
);
  localparam int unsigned SW = $clog2(NUNITS);
  localparam int unsigned TW = $clog2(TMOCNT + 1);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [NUNITS-1:0] gnt, gnt_nxt;
  logic [SW-1:0]     sel, sel_nxt;
  logic [SW-1:0]     ptr, ptr_nxt;
  logic [15:0]       wcnt, wcnt_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              tmo, tmo_nxt;

  logic              found;
  logic [SW-1:0]     win;

  // First requester at or after ptr, wrapping to unit 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUNITS; i++) begin
      if (!found && bus.req[ptr + SW'(i)]) begin
        found = 1'b1;
        win   = ptr + SW'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    wcnt_nxt  = wcnt;
    tcnt_nxt  = tcnt;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (found) begin
          gnt_nxt   = NUNITS'(1) << win;
          sel_nxt   = win;
          wcnt_nxt  = '0;
          tcnt_nxt  = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        // An ack wins over both the yield check and the terminal count.
        if (bus.devACKI) begin
          wcnt_nxt = wcnt + 16'd1;
          tcnt_nxt = '0;
          if (bus.last[sel]) begin
            gnt_nxt   = '0;
            state_nxt = RELEASE;
          end
        end else if (!bus.req[sel]) begin
          gnt_nxt   = '0;
          tcnt_nxt  = '0;
          state_nxt = RELEASE;
        end else if (tcnt == TW'(TMOCNT - 1)) begin
          gnt_nxt   = '0;
          tcnt_nxt  = '0;
          tmo_nxt   = 1'b1;
          state_nxt = RELEASE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      RELEASE: begin
        gnt_nxt   = '0;
        ptr_nxt   = sel + SW'(1);
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || devRESET) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      wcnt  <= '0;
      tcnt  <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      wcnt  <= wcnt_nxt;
      tcnt  <= tcnt_nxt;
      tmo   <= tmo_nxt;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.sel     = sel;
  assign bus.wcnt    = wcnt;
  assign bus.tmo     = tmo;
  assign bus.busy    = (state == XFER);
  assign bus.devREQO = (state == XFER) && bus.req[sel];
endmodule

// File: tb/tb_mb_drive_arb.sv
module tb_mb_drive_arb;
  logic clk = 1'b0;
  logic rst;
  logic dev_reset;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_gnt [3] = '{8'h01, 8'h80, 8'h01};

  mb_drive_arb_if #(.NUNITS(8)) bus();

  mb_drive_arb #(.NUNITS(8), .TMOCNT(1023)) dut (
    .clk      (clk),
    .rst      (rst),
    .devRESET (dev_reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; dev_reset = 1'b0;
    bus.req = '0; bus.last = '0; bus.devACKI = 1'b0;
    step(); step();
    rst = 1'b1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_wcnt", bus.wcnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tmo", bus.tmo, 0);
    check("rst_devreqo", bus.devREQO, 0);

    // ack while idle is ignored
    bus.devACKI = 1'b1; step();
    check("idle_ack_wcnt", bus.wcnt, 0);
    check("idle_ack_busy", bus.busy, 0);
    check("idle_ack_gnt", bus.gnt, 0);
    bus.devACKI = 1'b0;

    // unit 2, three words, last on the third
    bus.req = 8'h04; step();
    check("u2_gnt", bus.gnt, 8'h04);
    check("u2_sel", bus.sel, 2);
    check("u2_busy", bus.busy, 1);
    check("u2_devreqo", bus.devREQO, 1);
    check("u2_wcnt0", bus.wcnt, 0);
    bus.devACKI = 1'b1; step();
    check("u2_wcnt1", bus.wcnt, 1);
    step();
    check("u2_wcnt2", bus.wcnt, 2);
    bus.last = 8'h04; step();
    bus.devACKI = 1'b0; bus.last = '0; bus.req = '0;
    check("u2_wcnt3", bus.wcnt, 3);
    check("u2_rel_gnt", bus.gnt, 0);
    check("u2_rel_busy", bus.busy, 0);
    check("u2_rel_devreqo", bus.devREQO, 0);
    step();
    // ptr now 3: unit 3 must beat unit 2
    bus.req = 8'h0C; step();
    check("ptr3_gnt", bus.gnt, 8'h08);
    check("ptr3_sel", bus.sel, 3);
    bus.req = '0; step(); step();
    rst = 1'b0; step(); rst = 1'b1;

    // units 0 and 7 alternate
    bus.req = 8'h81; bus.last = 8'h81; step();
    for (int k = 0; k < 3; k++) begin
      check("rr_gnt", bus.gnt, exp_gnt[k]);
      check("rr_busy", bus.busy, 1);
      bus.devACKI = 1'b1; step();
      bus.devACKI = 1'b0;
      if (k == 2) begin bus.req = '0; bus.last = '0; end
      check("rr_rel_gnt", bus.gnt, 0);
      check("rr_rel_wcnt", bus.wcnt, 1);
      step();
      check("rr_idle_gnt", bus.gnt, 0);
      check("rr_idle_busy", bus.busy, 0);
      if (k < 2) step();
    end

    // unit 1 yields after two words
    bus.req = 8'h02; step();
    check("u1_gnt", bus.gnt, 8'h02);
    bus.devACKI = 1'b1; step(); step();
    bus.devACKI = 1'b0; bus.req = '0; step();
    check("u1_rel_gnt", bus.gnt, 0);
    check("u1_rel_busy", bus.busy, 0);
    check("u1_wcnt", bus.wcnt, 2);
    check("u1_tmo", bus.tmo, 0);
    step();

    // unit 5 times out
    bus.req = 8'h20; step();
    check("u5_gnt", bus.gnt, 8'h20);
    check("u5_sel", bus.sel, 5);
    repeat (1022) step();
    check("u5_pre_busy", bus.busy, 1);
    check("u5_pre_tmo", bus.tmo, 0);
    step();
    check("u5_tmo", bus.tmo, 1);
    check("u5_tmo_gnt", bus.gnt, 0);
    check("u5_tmo_wcnt", bus.wcnt, 0);
    check("u5_tmo_devreqo", bus.devREQO, 0);
    check("u5_tmo_busy", bus.busy, 0);
    bus.req = '0; step();
    check("u5_tmo_pulse", bus.tmo, 0);

    // unit 6: ack lands on the terminal count
    bus.req = 8'h40; step();
    check("u6_gnt", bus.gnt, 8'h40);
    repeat (1022) step();
    bus.devACKI = 1'b1; step();
    bus.devACKI = 1'b0;
    check("tc_ack_wcnt", bus.wcnt, 1);
    check("tc_ack_tmo", bus.tmo, 0);
    check("tc_ack_busy", bus.busy, 1);
    check("tc_ack_gnt", bus.gnt, 8'h40);
    step();
    check("tc_after_tmo", bus.tmo, 0);
    check("tc_after_busy", bus.busy, 1);

    // reset mid-tenure of unit 6
    rst = 1'b0; step();
    check("mid_rst_gnt", bus.gnt, 0);
    check("mid_rst_sel", bus.sel, 0);
    check("mid_rst_wcnt", bus.wcnt, 0);
    check("mid_rst_devreqo", bus.devREQO, 0);
    check("mid_rst_tmo", bus.tmo, 0);
    rst = 1'b1; bus.req = 8'h41; step();
    check("post_rst_gnt", bus.gnt, 8'h01);
    check("post_rst_sel", bus.sel, 0);

    // devRESET mid-tenure
    bus.devACKI = 1'b1; step();
    check("dr_wcnt1", bus.wcnt, 1);
    bus.devACKI = 1'b0; dev_reset = 1'b1; step();
    check("dr_gnt", bus.gnt, 0);
    check("dr_wcnt", bus.wcnt, 0);
    check("dr_busy", bus.busy, 0);
    check("dr_devreqo", bus.devREQO, 0);
    dev_reset = 1'b0; bus.req = '0; step();

    // rst beats a coincident request and ack
    rst = 1'b0; bus.req = 8'h10; bus.devACKI = 1'b1; step();
    check("prec_gnt", bus.gnt, 0);
    check("prec_busy", bus.busy, 0);
    check("prec_wcnt", bus.wcnt, 0);
    rst = 1'b1; bus.req = '0; bus.devACKI = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
